// File: rtl/imgproc_msg_reader_pkg.sv
// Shared constants for the image-processor message reader: slave register
// map, ID word, message tags, decode field indices and FSM state encodings.
package imgproc_msg_pkg;

  // Slave word addresses
  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_MSG    = 3'd1;
  localparam logic [2:0] ADDR_ID     = 3'd2;

  // Expected contents of the ID register
  localparam logic [31:0] ID_VALUE = 32'h1234EEE2;

  // Message tags found in bits [31:24]
  localparam logic [7:0] TAG_RED    = 8'h72;
  localparam logic [7:0] TAG_BLUE   = 8'h62;
  localparam logic [7:0] TAG_YELLOW = 8'h79;
  localparam logic [7:0] TAG_WALLS  = 8'h00;

  // Writing this status bit flushes the slave FIFO
  localparam int          FLUSH_BIT  = 4;
  localparam logic [31:0] FLUSH_WORD = 32'h1 << FLUSH_BIT;

  // Bit positions in the one-hot field select / dist_upd vector
  localparam int SEL_RED    = 0;
  localparam int SEL_BLUE   = 1;
  localparam int SEL_YELLOW = 2;
  localparam int SEL_WALLS  = 3;

  // Reader FSM state encodings
  typedef logic [3:0] state_t;
  localparam state_t S_RESET    = 4'd0;
  localparam state_t S_ID_RD    = 4'd1;
  localparam state_t S_ID_WAIT  = 4'd2;
  localparam state_t S_ID_HOLD  = 4'd3;
  localparam state_t S_IDLE     = 4'd4;
  localparam state_t S_FLUSH_WR = 4'd5;
  localparam state_t S_ST_RD    = 4'd6;
  localparam state_t S_ST_WAIT  = 4'd7;
  localparam state_t S_MSG_RD   = 4'd8;
  localparam state_t S_MSG_WAIT = 4'd9;
  localparam state_t S_PUSH     = 4'd10;

endpackage

// File: rtl/imgproc_msg_reader_if.sv
// Avalon-MM bus between the message reader (master) and the image
// processor's CPU slave port. Every transfer is one cycle with
// m_chipselect high; m_readdata is registered by the slave and valid
// in the cycle after the read strobe.
interface imgproc_msg_reader_if;
  logic        m_chipselect;
  logic        m_read;
  logic        m_write;
  logic [2:0]  m_address;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;

  modport master (
    output m_chipselect, m_read, m_write, m_address, m_writedata,
    input  m_readdata
  );

  modport slave (
    input  m_chipselect, m_read, m_write, m_address, m_writedata,
    output m_readdata
  );
endinterface

// File: rtl/imgproc_msg_reader_decode.sv
// Combinational tag decoder for one message word: one-hot field select
// ({walls, yellow, blue, red}), 11-bit distance payload, wall bits and an
// unknown-tag flag.
module imgproc_msg_decode
  import imgproc_msg_pkg::*;
(
  input  logic [31:0] word,
  output logic [3:0]  field_sel,
  output logic [10:0] payload,
  output logic [2:0]  wall_bits,
  output logic        unknown
);

  logic [7:0] tag;
  assign tag       = word[31:24];
  assign payload   = word[10:0];
  assign wall_bits = word[2:0];

  // A walls word must carry zeros everywhere above the three flag bits
  always_comb begin
    field_sel = '0;
    unknown   = 1'b0;
    case (tag)
      TAG_RED:    field_sel[SEL_RED]    = 1'b1;
      TAG_BLUE:   field_sel[SEL_BLUE]   = 1'b1;
      TAG_YELLOW: field_sel[SEL_YELLOW] = 1'b1;
      TAG_WALLS: begin
        if (word[28:3] == '0) field_sel[SEL_WALLS] = 1'b1;
        else                  unknown              = 1'b1;
      end
      default:    unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/imgproc_msg_reader.sv
// Hardware drain for the image processor's CPU message FIFO. Optionally
// verifies the slave ID, then polls the status register every
// POLL_INTERVAL cycles, reads up to MAX_BURST queued words, decodes them
// into latched beacon distances / wall flags and forwards each raw word.
//
// Stream handshake: msg_valid rises with msg_data and stays high, with
// msg_data held constant, until a cycle where msg_ready is also high; that
// cycle transfers the word. No new slave read is issued while a word is
// waiting, so words are never dropped.
module imgproc_msg_reader
  import imgproc_msg_pkg::*;
#(
  parameter int POLL_INTERVAL = 1000,
  parameter int MAX_BURST     = 16,
  parameter int CHECK_ID      = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  imgproc_msg_reader_if.master bus,
  input  logic                 flush_req,
  output logic [31:0]          msg_data,
  output logic                 msg_valid,
  input  logic                 msg_ready,
  output logic [10:0]          red_dist,
  output logic [10:0]          blue_dist,
  output logic [10:0]          yellow_dist,
  output logic [2:0]           walls,
  output logic [3:0]           dist_upd,
  output logic                 id_err,
  output logic [7:0]           unknown_cnt,
  output logic [3:0]           dbg_state
);

  localparam int            TW         = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(POLL_INTERVAL - 1);
  localparam logic [7:0]    BURST_CAP  = 8'(MAX_BURST);

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] timer;
  logic [7:0]    count;
  logic          flush_pend;

  logic [7:0]  status_cnt;
  logic [7:0]  burst_len;
  logic [3:0]  dec_sel;
  logic [10:0] dec_payload;
  logic [2:0]  dec_walls;
  logic        dec_unknown;
  logic        timer_wait;

  assign dbg_state  = state;
  assign status_cnt = bus.m_readdata[15:8];
  assign burst_len  = (status_cnt > BURST_CAP) ? BURST_CAP : status_cnt;
  assign timer_wait = (state == S_IDLE) || (state == S_ID_HOLD);

  imgproc_msg_decode u_decode (
    .word      (bus.m_readdata),
    .field_sel (dec_sel),
    .payload   (dec_payload),
    .wall_bits (dec_walls),
    .unknown   (dec_unknown)
  );

  // Next-state logic; a pending flush takes priority over the poll timer
  always_comb begin
    state_nx = state;
    case (state)
      S_RESET:    state_nx = (CHECK_ID != 0) ? S_ID_RD : S_IDLE;
      S_ID_RD:    state_nx = S_ID_WAIT;
      S_ID_WAIT:  state_nx = (bus.m_readdata == ID_VALUE) ? S_IDLE : S_ID_HOLD;
      S_ID_HOLD:  if (timer == '0) state_nx = S_ID_RD;
      S_IDLE: begin
        if (flush_pend)         state_nx = S_FLUSH_WR;
        else if (timer == '0)   state_nx = S_ST_RD;
      end
      S_FLUSH_WR: state_nx = S_IDLE;
      S_ST_RD:    state_nx = S_ST_WAIT;
      S_ST_WAIT:  state_nx = (burst_len == 8'd0) ? S_IDLE : S_MSG_RD;
      S_MSG_RD:   state_nx = S_MSG_WAIT;
      S_MSG_WAIT: state_nx = S_PUSH;
      S_PUSH: begin
        if (msg_ready) state_nx = (count == 8'd1) ? S_IDLE : S_MSG_RD;
      end
      default:    state_nx = S_RESET;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_RESET;
    else          state <= state_nx;
  end

  // Interval timer: reloads whenever IDLE or ID_HOLD is entered, counts down inside them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= TIMER_LOAD;
    end else if ((state_nx == S_IDLE || state_nx == S_ID_HOLD) && state_nx != state) begin
      timer <= TIMER_LOAD;
    end else if (timer_wait && timer != '0) begin
      timer <= timer - 1'b1;
    end
  end

  // Flush request latch; a request arriving during the write itself is kept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 flush_pend <= 1'b0;
    else if (flush_req)           flush_pend <= 1'b1;
    else if (state == S_FLUSH_WR) flush_pend <= 1'b0;
  end

  // Bus outputs are pure functions of the state: one cycle per transfer
  always_comb begin
    bus.m_chipselect = 1'b0;
    bus.m_read       = 1'b0;
    bus.m_write      = 1'b0;
    bus.m_address    = ADDR_STATUS;
    bus.m_writedata  = '0;
    case (state)
      S_ID_RD: begin
        bus.m_chipselect = 1'b1;
        bus.m_read       = 1'b1;
        bus.m_address    = ADDR_ID;
      end
      S_ST_RD: begin
        bus.m_chipselect = 1'b1;
        bus.m_read       = 1'b1;
        bus.m_address    = ADDR_STATUS;
      end
      S_MSG_RD: begin
        bus.m_chipselect = 1'b1;
        bus.m_read       = 1'b1;
        bus.m_address    = ADDR_MSG;
      end
      S_FLUSH_WR: begin
        bus.m_chipselect = 1'b1;
        bus.m_write      = 1'b1;
        bus.m_address    = ADDR_STATUS;
        bus.m_writedata  = FLUSH_WORD;
      end
      default: ;
    endcase
  end

  // Burst counter, holding register, decoded latches and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count       <= '0;
      msg_data    <= '0;
      msg_valid   <= 1'b0;
      red_dist    <= '0;
      blue_dist   <= '0;
      yellow_dist <= '0;
      walls       <= '0;
      dist_upd    <= '0;
      id_err      <= 1'b0;
      unknown_cnt <= '0;
    end else begin
      dist_upd <= '0;
      case (state)
        S_ID_WAIT: id_err <= (bus.m_readdata != ID_VALUE);
        S_ST_WAIT: count  <= burst_len;
        S_MSG_WAIT: begin
          msg_data  <= bus.m_readdata;
          msg_valid <= 1'b1;
          dist_upd  <= dec_sel;
          if (dec_sel[SEL_RED])    red_dist    <= dec_payload;
          if (dec_sel[SEL_BLUE])   blue_dist   <= dec_payload;
          if (dec_sel[SEL_YELLOW]) yellow_dist <= dec_payload;
          if (dec_sel[SEL_WALLS])  walls       <= dec_walls;
          if (dec_unknown && unknown_cnt != 8'hFF) unknown_cnt <= unknown_cnt + 8'd1;
        end
        S_PUSH: begin
          if (msg_ready) begin
            msg_valid <= 1'b0;
            count     <= count - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
